// File: rtl/result_uart_tx.sv
`default_nettype none
// ============================================================================
// Module  : result_uart_tx
// Brief   : FIFO-buffered UART transmitter for result bytes. The frame is 8N1 by
//           default, or 8E1 when RESULT_UART_PARITY_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int               c_aw      = $clog2(FIFO_DEPTH);
  localparam int               c_cw      = c_aw + 1;
  localparam logic [c_cw-1:0]  c_depth   = c_cw'(FIFO_DEPTH);
  localparam logic [c_aw-1:0]  c_ptr_one = c_aw'(1);
  localparam logic [15:0]      c_last    = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef RESULT_UART_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [c_aw-1:0]   wr_ptr_q, rd_ptr_q;
  logic [c_cw-1:0]   count_q, count_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic              w_push, w_pop, w_baud_last;

  assign in_ready    = (count_q != c_depth);
  assign fifo_count  = count_q;
  assign tx          = tx_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign w_push      = in_valid && in_ready;
  assign w_pop       = (state_q == S_IDLE) && (count_q != '0);
  assign w_baud_last = (baud_q == c_last);

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_cw'(1);
      2'b01:   count_d = count_q - c_cw'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (w_pop) begin
          state_d = S_START;
          shift_d = mem_q[rd_ptr_q];
          bit_d   = '0;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef RESULT_UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef RESULT_UART_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          state_d = S_STOP;
          baud_d  = '0;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_last) begin
          state_d = S_IDLE;
          baud_d  = '0;
          tx_done = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // The line level is chosen from the upcoming state so tx changes on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bit_d];
`ifdef RESULT_UART_PARITY_EN
      S_PARITY: tx_d = ^shift_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      count_q  <= count_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + c_ptr_one;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_ptr_one;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_result_uart_tx.sv
`default_nettype none
// Testbench for result_uart_tx: directed and random traffic compared cycle by cycle
// against a frame-level model of the UART line and FIFO occupancy.
module tb_result_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef RESULT_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, tx, busy, tx_done;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: a queue of accepted bytes plus the frame currently on the
  // line, tracked as a cycle offset k into a frame of NBITS*CPB cycles.
  logic [7:0] mq[$];
  bit         m_fly = 1'b0;
  int         m_k   = 0;
  logic [7:0] m_cur = 8'h00;
  bit         m_acc;

  function automatic logic exp_tx();
    int pos;
    if (!m_fly) return 1'b1;
    pos = m_k / CPB;
    if (pos == 0) return 1'b0;
    if (pos <= 8) return m_cur[pos-1];
`ifdef RESULT_UART_PARITY_EN
    if (pos == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_fly = 1'b0;
      m_k   = 0;
    end else begin
      m_acc = in_valid && (mq.size() != DEPTH);
      if (m_fly) begin
        if (m_k == FLEN - 1) m_fly = 1'b0;
        else m_k++;
      end else if (mq.size() != 0) begin
        m_cur = mq.pop_front();
        m_fly = 1'b1;
        m_k   = 0;
      end
      if (m_acc) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    check("tx",         32'(tx),         32'(exp_tx()));
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
    check("in_ready",   32'(in_ready),   32'(mq.size() != DEPTH));
    check("busy",       32'(busy),       32'(m_fly || (mq.size() != 0)));
    check("tx_done",    32'(tx_done),    32'(m_fly && (m_k == FLEN - 1)));
  end

  task automatic push(input logic [7:0] b);
    logic rdy;
    int   n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 500);
    if (!rdy) check("push_timeout", 32'(rdy), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_fly || mq.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 32'(m_fly || (mq.size() != 0)), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("async_tx",    32'(tx),         32'd1);
    check("async_count", 32'(fifo_count), 32'd0);
    check("async_busy",  32'(busy),       32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] burst [6] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h7E, 8'h55};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single byte into an idle block
    push(8'hA5);
    in_valid = 1'b0;
    drain();

    // Valid held high across a burst that overfills the FIFO
    foreach (burst[i]) push(burst[i]);
    in_valid = 1'b0;
    drain();

    // Push landing on the same edge as a pop with two entries queued
    push(8'h11);
    push(8'h22);
    push(8'h33);
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_done && n < 200);
    check("wait_tx_done", 32'(tx_done), 32'd1);
    @(posedge clk);
    #1;
    check("pre_pop_count", 32'(fifo_count), 32'd2);
    in_data  = 8'h81;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    check("same_edge_count", 32'(fifo_count), 32'd2);
    drain();

    // Reset in the middle of a frame, then a clean frame
    push(8'hC3);
    in_valid = 1'b0;
    repeat (14) @(posedge clk);
    check("pre_reset_tx_low", 32'(tx), 32'd0);
    async_reset();
    push(8'h5A);
    in_valid = 1'b0;
    drain();

    // Back-to-back frames exercising the parity bit when enabled
    push(8'hA5);
    push(8'h01);
    in_valid = 1'b0;
    drain();

    // Random traffic with one reset dropped in mid-run
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 60; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        @(posedge clk);
        #1;
        if (r == 1 && i == 30) begin
          in_valid = 1'b0;
          async_reset();
        end
      end
      in_valid = 1'b0;
      drain();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
